// File: rtl/i2s_tx_ctrl_if.sv
// Stereo-pair handshake between a sample source (master) and the I2S transmitter (slave).
interface i2s_tx_ctrl_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] left_data_in;
    logic [DATA_WIDTH-1:0] right_data_in;
    logic                  data_valid_in;
    logic                  data_ready_out;

    modport master (
        output left_data_in,
        output right_data_in,
        output data_valid_in,
        input  data_ready_out
    );

    modport slave (
        input  left_data_in,
        input  right_data_in,
        input  data_valid_in,
        output data_ready_out
    );
endinterface

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit serializer: one-pair holding register, LEFT/RIGHT slot sequencing from the
// external lrck/sclk divider, MSB-first output with the standard one-bit delay.
module i2s_tx_ctrl #(
    parameter int DATA_WIDTH = 24
) (
    input  logic         mclk_in,
    input  logic         rst_n_in,
    input  logic         lrck_in,
    input  logic         sclk_in,
    i2s_tx_ctrl_if.slave pair_if,
    output logic         sdata_out,
    output logic         underrun_out
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  sclk_dly_q, lrck_dly_q;
    logic                  sclk_fall, lrck_fall, lrck_rise;
    logic                  hold_full_q, hold_full_d;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
    logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rword_q, rword_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  restart_q, restart_d;
    logic                  sdata_q, sdata_d;
    logic                  underrun_q, underrun_d;
    logic                  accept;
    logic                  start_left, start_right;

    assign sclk_fall = sclk_dly_q & ~sclk_in;
    assign lrck_fall = lrck_dly_q & ~lrck_in;
    assign lrck_rise = ~lrck_dly_q & lrck_in;

    // ready mirrors ~hold_full, so an accept can never land on a load cycle
    assign accept = pair_if.data_valid_in & ready_q;

    assign pair_if.data_ready_out = ready_q;
    assign sdata_out              = sdata_q;
    assign underrun_out           = underrun_q;

    always_ff @(posedge mclk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= SYNC;
            sclk_dly_q   <= 1'b0;
            lrck_dly_q   <= 1'b0;
            hold_full_q  <= 1'b0;
            ready_q      <= 1'b1;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            shift_q      <= '0;
            rword_q      <= '0;
            cnt_q        <= '0;
            restart_q    <= 1'b0;
            sdata_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_dly_q   <= sclk_in;
            lrck_dly_q   <= lrck_in;
            hold_full_q  <= hold_full_d;
            ready_q      <= ~hold_full_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            shift_q      <= shift_d;
            rword_q      <= rword_d;
            cnt_q        <= cnt_d;
            restart_q    <= restart_d;
            sdata_q      <= sdata_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_full_d  = hold_full_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        shift_d      = shift_q;
        rword_d      = rword_q;
        cnt_d        = cnt_q;
        restart_d    = restart_q;
        sdata_d      = sdata_q;
        underrun_d   = 1'b0;
        start_left   = 1'b0;
        start_right  = 1'b0;

        case (state_q)
            SYNC:    start_left  = lrck_fall;
            LEFT:    start_right = lrck_rise;
            RIGHT:   start_left  = lrck_fall;
            default: state_d     = SYNC;
        endcase

        if (accept) begin
            hold_full_d  = 1'b1;
            hold_left_d  = pair_if.left_data_in;
            hold_right_d = pair_if.right_data_in;
        end

        if (start_left) begin
            state_d = LEFT;
            if (hold_full_q) begin
                shift_d     = hold_left_q;
                rword_d     = hold_right_q;
                hold_full_d = 1'b0;
            end else begin
                shift_d    = '0;
                rword_d    = '0;
                underrun_d = 1'b1;
            end
        end

        if (start_right) begin
            state_d = RIGHT;
            shift_d = rword_q;
        end

        // An lrck edge without a coincident sclk fall defers the counter clear (and the
        // one-bit-delay hold of sdata) to the next sclk fall via restart_q.
        if (start_left || start_right) begin
            if (sclk_fall) begin
                cnt_d     = '0;
                restart_d = 1'b0;
            end else begin
                restart_d = 1'b1;
            end
        end else if (sclk_fall && (state_q != SYNC)) begin
            if (restart_q) begin
                cnt_d     = '0;
                restart_d = 1'b0;
            end else if (cnt_q < CNT_MAX) begin
                sdata_d = shift_q[DATA_WIDTH-1];
                shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
            end else begin
                sdata_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench: 24-bit instance on a 256/4 divider and a 32-bit instance on a 128/4
// divider (16 sclk per half frame) sharing mclk, sclk and reset.
module tb_i2s_tx_ctrl;

    logic       mclk = 1'b0;
    logic       rst_n;
    logic       sclk, lrck, lrck2;
    logic [7:0] div;
    logic       sdata1, und1, sdata2, und2;
    int         nerr = 0;
    int         nchk = 0;
    int         k    = 0;

    localparam logic [31:0] L2C = 32'hDEADBEEF;
    localparam logic [31:0] R2C = 32'h12345678;

    i2s_tx_ctrl_if #(.DATA_WIDTH(24)) if1 ();
    i2s_tx_ctrl_if #(.DATA_WIDTH(32)) if2 ();

    i2s_tx_ctrl #(.DATA_WIDTH(24)) dut1 (
        .mclk_in     (mclk),
        .rst_n_in    (rst_n),
        .lrck_in     (lrck),
        .sclk_in     (sclk),
        .pair_if     (if1),
        .sdata_out   (sdata1),
        .underrun_out(und1)
    );

    i2s_tx_ctrl #(.DATA_WIDTH(32)) dut2 (
        .mclk_in     (mclk),
        .rst_n_in    (rst_n),
        .lrck_in     (lrck2),
        .sclk_in     (sclk),
        .pair_if     (if2),
        .sdata_out   (sdata2),
        .underrun_out(und2)
    );

    always #5 mclk = ~mclk;

    // sclk = mclk/4, lrck = mclk/256, lrck2 = mclk/128; lrck edges land on sclk falls
    initial begin
        div   = 8'd0;
        sclk  = 1'b0;
        lrck  = 1'b0;
        lrck2 = 1'b0;
        forever begin
            @(posedge mclk);
            #1;
            div   = div + 8'd1;
            sclk  = div[1];
            lrck  = div[7];
            lrck2 = div[6];
        end
    end

    function automatic logic [23:0] pat_l(input int n);
        return {16'hA55A, 8'(n)};
    endfunction

    function automatic logic [23:0] pat_r(input int n);
        return {16'h3CC3, 8'(n)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_div(input logic [7:0] n);
        int t = 0;
        do begin
            @(negedge mclk);
            t++;
        end while (div != n && t < 600);
        if (div != n) check("wait_div", 32'(div), 32'(n));
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r, input bit keep);
        int t = 0;
        if1.left_data_in  = l;
        if1.right_data_in = r;
        if1.data_valid_in = 1'b1;
        while (!if1.data_ready_out && t < 600) begin
            @(negedge mclk);
            t++;
        end
        if (!if1.data_ready_out) check("push_ready", 32'(if1.data_ready_out), 32'd1);
        @(posedge mclk);
        #1;
        if (keep) begin
            k = 1;
            if1.left_data_in  = pat_l(k);
            if1.right_data_in = pat_r(k);
        end else begin
            if1.data_valid_in = 1'b0;
        end
    endtask

    // Idle observation from now to the end of the current frame: DUT1 must stay silent.
    task automatic watch_idle(input string tag);
        int ones = 0;
        int unds = 0;
        int t    = 0;
        do begin
            @(negedge mclk);
            t++;
            if (sdata1 === 1'b1) ones++;
            if (und1 === 1'b1) unds++;
        end while (div != 8'd255 && t < 600);
        check({tag, "_sdata_ones"}, 32'(ones), 32'd0);
        check({tag, "_underruns"}, 32'(unds), 32'd0);
    endtask

    // One full 256-mclk frame of DUT1 (and two frames of DUT2 when chk2 is set).
    task automatic run_frame(input string tag, input logic [23:0] l, input logic [23:0] r,
                             input int exp_und, input int exp_acc, input bit chk2);
        int          unds  = 0;
        int          unds2 = 0;
        int          acc   = 0;
        int          acc_div = -1;
        int          s;
        logic [23:0] w;
        logic [31:0] w2;
        logic [31:0] l2v, r2v;
        logic        e;
        l2v = L2C;
        r2v = R2C;
        wait_div(8'd0);
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge mclk);
            if (und1 === 1'b1) unds++;
            if (und2 === 1'b1) unds2++;
            if (div[1:0] == 2'd2) begin
                s = int'(div[6:2]);
                w = div[7] ? r : l;
                e = (s >= 1 && s <= 24) ? w[24-s] : 1'b0;
                check($sformatf("%s_%s_slot%0d", tag, div[7] ? "R" : "L", s), 32'(sdata1), 32'(e));
                if (chk2) begin
                    s  = int'(div[5:2]);
                    w2 = div[6] ? r2v : l2v;
                    e  = (s >= 1) ? w2[32-s] : (div[6] ? l2v[17] : r2v[17]);
                    check($sformatf("%s_w32_%s_slot%0d", tag, div[6] ? "R" : "L", s),
                          32'(sdata2), 32'(e));
                end
            end
            if (if1.data_valid_in && if1.data_ready_out) begin
                acc++;
                acc_div = int'(div);
                @(posedge mclk);
                #1;
                k++;
                if1.left_data_in  = pat_l(k);
                if1.right_data_in = pat_r(k);
            end
        end
        check({tag, "_underruns"}, 32'(unds), 32'(exp_und));
        check({tag, "_accepts"}, 32'(acc), 32'(exp_acc));
        if (exp_acc == 1) check({tag, "_accept_div"}, 32'(acc_div), 32'd1);
        if (chk2) check({tag, "_w32_underruns"}, 32'(unds2), 32'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        if1.left_data_in  = '0;
        if1.right_data_in = '0;
        if1.data_valid_in = 1'b0;
        if2.left_data_in  = L2C;
        if2.right_data_in = R2C;
        if2.data_valid_in = 1'b1;

        wait_div(8'd5);
        check("rst_ready1", 32'(if1.data_ready_out), 32'd1);
        check("rst_sdata1", 32'(sdata1), 32'd0);
        check("rst_und1", 32'(und1), 32'd0);
        check("rst_ready2", 32'(if2.data_ready_out), 32'd1);
        check("rst_sdata2", 32'(sdata2), 32'd0);
        check("rst_und2", 32'(und2), 32'd0);

        // Release mid-frame; the pair is accepted while still in SYNC.
        wait_div(8'd20);
        rst_n = 1'b1;
        push(24'hA5A5A5, 24'h5A5A5A, 1'b0);
        @(negedge mclk);
        check("sync_ready_after_accept", 32'(if1.data_ready_out), 32'd0);
        watch_idle("sync0");

        run_frame("first", 24'hA5A5A5, 24'h5A5A5A, 0, 0, 1'b0);
        run_frame("starve1", 24'h0, 24'h0, 1, 0, 1'b1);
        run_frame("starve2", 24'h0, 24'h0, 1, 0, 1'b1);

        // Continuous valid with an incrementing pattern.
        push(pat_l(0), pat_r(0), 1'b1);
        run_frame("stream0", pat_l(0), pat_r(0), 0, 1, 1'b1);
        run_frame("stream1", pat_l(1), pat_r(1), 0, 1, 1'b1);
        run_frame("stream2", pat_l(2), pat_r(2), 0, 1, 1'b1);
        if1.data_valid_in = 1'b0;

        // Asynchronous reset in the middle of a left slot carrying pattern 3.
        wait_div(8'd10);
        push(24'h111111, 24'h222222, 1'b0);
        wait_div(8'd42);
        check("pre_rst_sdata", 32'(sdata1), 32'd1);
        check("pre_rst_ready", 32'(if1.data_ready_out), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sdata1", 32'(sdata1), 32'd0);
        check("async_rst_und1", 32'(und1), 32'd0);
        check("async_rst_ready1", 32'(if1.data_ready_out), 32'd1);
        check("async_rst_sdata2", 32'(sdata2), 32'd0);
        check("async_rst_ready2", 32'(if2.data_ready_out), 32'd1);
        wait_div(8'd60);
        rst_n = 1'b1;
        push(24'h800001, 24'hFFFFFF, 1'b0);
        watch_idle("sync1");
        run_frame("post_rst", 24'h800001, 24'hFFFFFF, 0, 0, 1'b1);
        run_frame("post_rst_starve", 24'h0, 24'h0, 1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/i2s_tx_ctrl.md
I2S_TX_CTRL -- requirements
Module: i2s_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 24: bits per channel sample, legal range 8..32.
REQ-002 mclk_in  input  1  master clock; the only clock; all logic on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-004 lrck_in  input  1  word-select from the I2S clock divider; 0 = left, 1 = right; synchronous to mclk_in.
REQ-005 sclk_in  input  1  bit clock from the same divider; synchronous to mclk_in; high and low phases each at least 2 mclk cycles.
REQ-006 left_data_in  input  DATA_WIDTH  left sample, two's complement.
REQ-007 right_data_in  input  DATA_WIDTH  right sample, two's complement.
REQ-008 data_valid_in  input  1  stereo pair offered.
REQ-009 data_ready_out  output  1  holding register empty; pair accepted on a cycle where valid and ready are both 1.
REQ-010 sdata_out  output  1  I2S serial data.
REQ-011 underrun_out  output  1  one-cycle pulse: a left slot started with no pair held.

Function
REQ-012 The block SHALL register sclk_in and lrck_in once (sclk_d, lrck_d).
- sclk_fall = sclk_d & ~sclk_in.
- lrck_fall = lrck_d & ~lrck_in.
- lrck_rise = ~lrck_d & lrck_in.
REQ-013 Holding register:
- one stereo pair plus hold_full flag.
- data_ready_out = ~hold_full, registered.
- accept sets hold_full.
- a load into the shift register clears hold_full.
- an accept and a load never coincide.
REQ-014 FSM states SHALL be SYNC, LEFT, RIGHT; reset enters SYNC.
REQ-015 SYNC -> LEFT on lrck_fall; LEFT -> RIGHT on lrck_rise; RIGHT -> LEFT on lrck_fall; lrck_rise in SYNC is ignored.
REQ-016 On lrck_fall (entering LEFT) the block SHALL take these actions.
- If hold_full: load left into the shift register, stash right in a right-word register, clear hold_full.
- Otherwise: load zeros into both, pulse underrun_out in that same cycle.
REQ-017 On lrck_rise (LEFT -> RIGHT) the block SHALL load the stashed right word into the shift register.
REQ-018 On the sclk_fall coinciding with an lrck edge, the block SHALL clear the bit counter and leave sdata_out unchanged (I2S one-bit delay).
REQ-019 On each later sclk_fall in LEFT/RIGHT, sdata_out SHALL take the next word bit, MSB first, while bit counter < DATA_WIDTH, then 0 until the next lrck edge.
REQ-020 sdata_out SHALL be registered, changing exactly one mclk cycle after the sclk_in high-to-low transition.
REQ-021 In SYNC, sdata_out SHALL stay 0 and no underrun SHALL be flagged; the holding register still accepts one pair.
REQ-022 Short slots: if an lrck edge arrives before DATA_WIDTH bits are sent, the remaining bits SHALL be dropped and the new slot starts normally (truncation, no error).
REQ-023 The bit counter SHALL saturate at DATA_WIDTH and never wrap within a slot.
REQ-024 lrck edges without a coinciding sclk_fall SHALL still switch channel and load the word; the counter SHALL clear on the next sclk_fall.

Reset
REQ-025 rst_n_in low SHALL immediately force the following, regardless of state or an in-flight slot:
- state SYNC
- sdata_out 0
- underrun_out 0
- data_ready_out 1
- hold_full 0
- shift, right-word and counter registers 0
- sclk_d and lrck_d 0
REQ-026 After release, the first lrck_fall SHALL start a left slot; a partial frame in progress at release SHALL be discarded.

Verification
REQ-027 Divider 256/4, DATA_WIDTH=24, pair L=0xA5A5A5 R=0x5A5A5A offered before the first lrck_fall. Required:
- sdata_out is 0 on the first bit slot.
- L appears MSB-first on bits 1..24, then zeros to bit 31.
- R follows likewise after lrck_rise.
REQ-028 No pair ever offered -> underrun_out pulses exactly once per lrck_fall and sdata_out stays 0.
REQ-029 data_valid_in held 1 continuously -> exactly one accept per frame, on the cycle after each lrck_fall; no pair dropped or duplicated (checked with an incrementing pattern).
REQ-030 DATA_WIDTH=32 with 16 sclk per half frame -> only the top 15 bits of each word are sent; the next slot starts correctly.
REQ-031 rst_n_in pulsed low mid-left-slot -> outputs reach reset values without waiting for a clock edge; no sdata activity until the next lrck_fall, then normal frames.
